// File: rtl/wb_queue.sv
// Writeback queue: two producers (load unit has priority) feed an in-order FIFO
// that drains one register-file write per cycle. `WB_FWD_EN adds operand forwarding.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        W_en,
  output logic [4:0]  Rd,
  output logic [31:0] Wr_data,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        pend1,
  output logic        pend2,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic        idle
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic [4:0]    r_rd_mem   [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];

  logic        w_full, w_empty, w_acc, w_push, w_pop;
  logic [4:0]  w_in_rd;
  logic [31:0] w_in_data;

  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign b_ready   = !w_full;
  assign a_ready   = !w_full & !b_valid;
  assign w_acc     = (b_valid & b_ready) | (a_valid & a_ready);
  assign w_in_rd   = b_valid ? b_rd : a_rd;
  assign w_in_data = b_valid ? b_data : a_data;
  // x0 writes finish the handshake but never occupy a slot
  assign w_push    = w_acc & (w_in_rd != 5'd0);
  assign w_pop     = !w_empty;
  assign idle      = w_empty & !W_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      W_en    <= 1'b0;
      Rd      <= '0;
      Wr_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      W_en <= w_pop;
      if (w_pop) begin
        Rd      <= r_rd_mem[r_rptr];
        Wr_data <= r_data_mem[r_rptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= w_in_rd;
      r_data_mem[r_wptr] <= w_in_data;
    end
  end

  logic [1:0][4:0]  w_q;
  logic [1:0]       w_pend;
  logic [1:0][31:0] w_fdata;
  logic [DEPTH-1:0] w_vld;
  assign w_q = {q_rs2, q_rs1};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_vld[i] = ((PW+1)'(i) < r_count);
  end

  // Scan oldest (output register) to youngest (tail) so the last match wins.
  always_comb begin
    w_pend  = '0;
    w_fdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (W_en && Rd == w_q[p]) begin
        w_pend[p]  = 1'b1;
        w_fdata[p] = Wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (w_vld[i] && r_rd_mem[r_rptr + PW'(i)] == w_q[p]) begin
          w_pend[p]  = 1'b1;
          w_fdata[p] = r_data_mem[r_rptr + PW'(i)];
        end
      end
      if (w_q[p] == 5'd0) begin
        w_pend[p]  = 1'b0;
        w_fdata[p] = '0;
      end
    end
  end

  assign pend1 = w_pend[0];
  assign pend2 = w_pend[1];

`ifdef WB_FWD_EN
  assign fwd1_hit  = w_pend[0];
  assign fwd2_hit  = w_pend[1];
  assign fwd1_data = w_fdata[0];
  assign fwd2_data = w_fdata[1];
`else
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule
